uart_rx_sampler: RTL and testbench



---
 rtl/uart_rx_sampler.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// UART receiver front end: 2-flop synchroniser, start-edge detect, 3-sample mid-bit vote.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Frame_Err,
    output logic       o_RX_Parity_Err,
    output logic       o_RX_Busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int H  = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(H);
    localparam logic [CW-1:0] CNT_RES  = CW'(H + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          rx_meta;
    logic          rx_s;
    logic          rx_s_d;
    logic [CW-1:0] clk_cnt;
    logic [CW-1:0] cnt_n;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_n;
    logic [7:0]    shreg;
    logic [7:0]    shreg_n;
    logic          samp_a;
    logic          samp_a_n;
    logic          samp_b;
    logic          samp_b_n;
    logic [7:0]    byte_q;
    logic [7:0]    byte_n;
    logic          dv_q;
    logic          dv_n;
    logic          ferr_q;
    logic          ferr_n;
    logic          busy_q;
    logic          busy_n;
    logic          last;
    logic          resolve;
    logic          maj;

`ifdef UART_RX_PARITY_EN
    logic          par_bad;
    logic          par_bad_n;
    logic          perr_q;
    logic          perr_n;
`endif

    assign last    = (clk_cnt == CNT_LAST);
    assign resolve = (clk_cnt == CNT_RES);
    // third sample is the live rx_s at the resolve count
    assign maj     = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= i_RX_Serial;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            samp_a  <= 1'b1;
            samp_b  <= 1'b1;
            byte_q  <= '0;
            dv_q    <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            clk_cnt <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
            samp_a  <= samp_a_n;
            samp_b  <= samp_b_n;
            byte_q  <= byte_n;
            dv_q    <= dv_n;
            ferr_q  <= ferr_n;
            busy_q  <= busy_n;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_n;
            perr_q  <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = clk_cnt;
        bit_n    = bit_idx;
        shreg_n  = shreg;
        samp_a_n = samp_a;
        samp_b_n = samp_b;
        byte_n   = byte_q;
        dv_n     = 1'b0;
        ferr_n   = 1'b0;
        busy_n   = busy_q;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
        perr_n    = 1'b0;
`endif

        if (clk_cnt == CNT_S0) samp_a_n = rx_s;
        if (clk_cnt == CNT_S1) samp_b_n = rx_s;
        if (state != S_IDLE && state != S_BREAK)
            cnt_n = last ? '0 : clk_cnt + CW'(1);

        unique case (state)
            S_IDLE: begin
                cnt_n  = '0;
                busy_n = 1'b0;
                // the edge cycle itself is count 0 of the start bit
                if (rx_s_d && !rx_s) begin
                    state_n = S_START;
                    cnt_n   = CW'(1);
                    bit_n   = '0;
                    busy_n  = 1'b1;
                end
            end
            S_START: begin
                if (resolve && maj) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                end else if (last) begin
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (resolve) shreg_n = {maj, shreg[7:1]};
                if (last) begin
                    bit_n = bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx == 3'd7) state_n = S_PARITY;
`else
                    if (bit_idx == 3'd7) state_n = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (resolve) par_bad_n = (^shreg) ^ maj;
                if (last) state_n = S_STOP;
            end
`endif
            S_STOP: begin
                // resolve mid stop bit so back-to-back frames are caught
                if (resolve) begin
                    cnt_n  = '0;
                    busy_n = 1'b0;
                    if (!maj) begin
                        ferr_n  = 1'b1;
                        state_n = S_BREAK;
                    end else begin
                        state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad) begin
                            perr_n = 1'b1;
                        end else begin
                            dv_n   = 1'b1;
                            byte_n = shreg;
                        end
`else
                        dv_n   = 1'b1;
                        byte_n = shreg;
`endif
                    end
                end
            end
            S_BREAK: begin
                cnt_n  = '0;
                busy_n = 1'b1;
                if (rx_s) begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign o_RX_DV        = dv_q;
    assign o_RX_Byte      = byte_q;
    assign o_RX_Frame_Err = ferr_q;
    assign o_RX_Busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign o_RX_Parity_Err = perr_q;
`else
    assign o_RX_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: builds line waveforms per clock and decodes them with
// a per-bit majority reference to predict strobe cycles, kinds and bytes.
module tb_uart_rx_sampler;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    localparam int K_DV = 1;
    localparam int K_FE = 2;
    localparam int K_PE = 3;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] b;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       dv;
    logic [7:0] rbyte;
    logic       fe;
    logic       pe;
    logic       busy;

    int         n_chk = 0;
    int         n_pass = 0;
    int         multi = 0;
    int         busy_strobe = 0;
    int         first_run;
    logic       run_done;
    logic [7:0] exp_byte = 8'h00;
    logic       line[$];
    ev_t        exp_q[$];
    ev_t        got_q[$];

    uart_rx_sampler #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock         (clk),
        .i_Rst_n         (rst_n),
        .i_RX_Serial     (rx),
        .o_RX_DV         (dv),
        .o_RX_Byte       (rbyte),
        .o_RX_Frame_Err  (fe),
        .o_RX_Parity_Err (pe),
        .o_RX_Busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic add_idle(input int n);
        for (int t = 0; t < n; t++) line.push_back(1'b1);
    endtask

    // start, data LSB first, optional even parity (flipped by par_flip), stop
    task automatic add_frame(input logic [7:0] b, input int stop_low,
                             input int noise_bit, input logic par_flip);
        logic [9:0] fr;
        logic       v;
        fr = {(^b) ^ par_flip, b, 1'b0};
        for (int k = 0; k < NB; k++)
            for (int t = 0; t < CPB; t++) begin
                v = fr[k];
                if (k == noise_bit && t == H) v = ~v;
                line.push_back(v);
            end
        if (stop_low == 0) add_idle(CPB);
        else for (int t = 0; t < stop_low * CPB; t++) line.push_back(1'b0);
    endtask

    function automatic logic vote(input int i, input int k);
        int c;
        c = i + k * CPB + H;
        return (line[c-1] & line[c]) | (line[c-1] & line[c+1]) | (line[c] & line[c+1]);
    endfunction

    // reference decoder: line index i is the first low sample after a high one
    task automatic model(input int lim);
        int         i;
        int         j;
        int         base;
        logic [7:0] b;
        logic       p;
        ev_t        e;
        exp_q.delete();
        i = 1;
        while (i < lim) begin
            if (!(line[i-1] && !line[i])) begin
                i++;
                continue;
            end
            base = i + NB * CPB + H + 2;
            if (base + 2 > lim) break;
            if (vote(i, 0)) begin
                i = i + H + 2;
                continue;
            end
            for (int k = 0; k < 8; k++) b[k] = vote(i, k + 1);
            p = 1'b0;
`ifdef UART_RX_PARITY_EN
            p = (^b) ^ vote(i, 9);
`endif
            e.cyc = base + 2;
            e.b   = exp_byte;
            if (!vote(i, NB)) begin
                e.kind = K_FE;
                j = base;
                while (j < lim && !line[j]) j++;
                i = j + 1;
            end else begin
                if (p) begin
                    e.kind = K_PE;
                end else begin
                    e.kind   = K_DV;
                    e.b      = b;
                    exp_byte = b;
                end
                i = base;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic run_seg(input string name, input int rst_at);
        int lim;
        add_idle(2 * CPB);
        lim = (rst_at >= 0) ? rst_at : line.size();
        model(lim);
        if (rst_at >= 0) exp_byte = 8'h00;
        got_q.delete();
        first_run = 0;
        run_done  = 1'b0;
        for (int c = 0; c < line.size(); c++) begin
            @(posedge clk);
            #1 rx = line[c];
            if (rst_at >= 0 && c == rst_at + 3) rst_n = 1'b1;
            @(negedge clk);
            if (dv) got_q.push_back('{c, K_DV, rbyte});
            if (fe) got_q.push_back('{c, K_FE, rbyte});
            if (pe) got_q.push_back('{c, K_PE, rbyte});
            if ($countones({dv, fe, pe}) > 1) multi++;
            if ((dv | fe | pe) && busy) busy_strobe++;
            if (!run_done) begin
                if (busy) first_run++;
                else if (first_run > 0) run_done = 1'b1;
            end
            if (c == rst_at) begin
                #1 rst_n = 1'b0;
                #1 chk({name, "_rst_async"}, {20'd0, dv, fe, pe, busy, rbyte}, 32'd0);
            end
        end
        chk({name, "_nev"}, got_q.size(), exp_q.size());
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            chk({name, "_cyc"}, got_q[k].cyc, exp_q[k].cyc);
            chk({name, "_kind"}, got_q[k].kind, exp_q[k].kind);
            chk({name, "_byte_at_strobe"}, got_q[k].b, exp_q[k].b);
        end
        chk({name, "_byte_end"}, rbyte, exp_byte);
        chk({name, "_busy_end"}, busy, 0);
        line.delete();
    endtask

    initial begin
        logic [9:0] fr;
        int         nb;
        int         sl;
        logic [7:0] rb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_dv", dv, 0);
        chk("reset_byte", rbyte, 8'h00);
        chk("reset_fe", fe, 0);
        chk("reset_pe", pe, 0);
        chk("reset_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        add_idle(4);
        add_frame(8'hA5, 0, -1, 1'b0);
        run_seg("valid_a5", -1);

        add_idle(4);
        repeat (3) line.push_back(1'b0);
        add_idle(3 * CPB);
        add_frame(8'h66, 0, -1, 1'b0);
        run_seg("glitch", -1);
        chk("glitch_busy_len", (first_run >= H && first_run <= H + 2), 1);

        add_idle(4);
        add_frame(8'h08, 0, 4, 1'b0);
        run_seg("noise_08", -1);

        add_idle(4);
        add_frame(8'h3C, 3, -1, 1'b0);
        add_idle(2 * CPB);
        add_frame(8'h0D, 0, -1, 1'b0);
        run_seg("frame_err", -1);

        add_idle(4);
        add_frame(8'h0D, 0, -1, 1'b0);
        add_frame(8'h0A, 0, -1, 1'b0);
        run_seg("b2b", -1);
        if (got_q.size() >= 2)
            chk("b2b_gap", got_q[1].cyc - got_q[0].cyc, (NB + 1) * CPB);
        else
            chk("b2b_count", got_q.size(), 2);

        add_idle(4);
        fr = {1'b1, 8'hC3, 1'b0};
        for (int t = 0; t < 5 * CPB + 8; t++) begin
            nb = t / CPB;
            line.push_back(fr[nb]);
        end
        run_seg("reset_mid", 4 + 5 * CPB + 6);

        add_idle(4);
        add_frame(8'h55, 0, -1, 1'b0);
        run_seg("after_reset", -1);

`ifdef UART_RX_PARITY_EN
        add_idle(4);
        add_frame(8'h07, 0, -1, 1'b1);
        add_idle(CPB);
        add_frame(8'h07, 0, -1, 1'b0);
        run_seg("parity", -1);
`endif

        add_idle(4);
        for (int f = 0; f < 12; f++) begin
            rb = 8'($urandom);
            sl = ($urandom_range(5) == 0) ? $urandom_range(3, 1) : 0;
            add_frame(rb, sl, ($urandom_range(1) == 1) ? $urandom_range(8, 1) : -1,
                      1'($urandom_range(3) == 0));
            add_idle((sl > 0) ? CPB : $urandom_range(2 * CPB, 0));
        end
        run_seg("random", -1);

        chk("strobes_exclusive", multi, 0);
        chk("busy_low_on_strobe", busy_strobe, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
